pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline-control block for the 5-stage core. Replaces the inline load-use stall, forwarding and branch-flush logic in the CPU top.
- A per-register scoreboard of result-ready countdowns generalises load-use detection to any result latency.
- Branch resolve stage is selectable (EX or MEM).
- Adds a global freeze for a multi-cycle data memory (mem_busy_i).

Parameters:
- REG_ADDR_W, 5: register index width.
- NUM_REGS, 32: scoreboard entries (2**REG_ADDR_W max).
- LOAD_LAT, 2: cycles from issue into EX until a load result can be forwarded. Min 1; an ALU result has latency 0.
- CNT_W, 2: countdown width; must hold LOAD_LAT.
- BR_STAGE, 3: branch resolve stage (2 = EX, 3 = MEM).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- id_valid_i  in  1  ID holds a real instruction
- id_rs_i, id_rt_i  in  REG_ADDR_W  ID source indices
- id_use_rs_i, id_use_rt_i  in  1  source actually read
- id_regwrite_i, id_memread_i  in  1  ID instruction writes a register / is a load
- id_dst_i  in  REG_ADDR_W  ID destination (after regdst select)
- ex_rs_i, ex_rt_i  in  REG_ADDR_W  EX source indices
- mem_regwrite_i, mem_memread_i  in  1  MEM-stage controls
- mem_dst_i  in  REG_ADDR_W  MEM destination
- wb_regwrite_i  in  1  WB writes a register
- wb_dst_i  in  REG_ADDR_W  WB destination
- branch_taken_i  in  1  taken branch at resolve stage
- mem_busy_i  in  1  data memory not ready; whole pipe holds
- stall_front_o  out  1  hold PC and IF/ID
- bubble_ex_o  out  1  clear ID/EX (insert NOP)
- freeze_o  out  1  hold all pipeline registers
- flush_if_id_o, flush_id_ex_o, flush_ex_mem_o  out  1  branch flushes
- fwd_a_o, fwd_b_o  out  2  EX operand select (package encoding)
- perf_stall_cnt_o, perf_flush_cnt_o  out  32  perf counters (feature-gated)

Behaviour:
- Reset: rst_i asserted, async. Scoreboard cleared, perf counters 0. All outputs forced 0 while rst_i is high.
- Scoreboard: cnt[r], CNT_W bits per register. Register 0 is never tracked and never forwarded.
- issue = id_valid_i & ~stall & ~freeze & ~flush_id_ex_o.
- On issue with id_regwrite_i and id_dst_i != 0: cnt[id_dst_i] <= id_memread_i ? LOAD_LAT-1 : 0.
  - All other nonzero entries decrement by 1 on every non-frozen cycle.
  - Set takes priority over decrement on the same entry.
- stall = id_valid_i & ((id_use_rs_i & cnt[id_rs_i] != 0) | (id_use_rt_i & cnt[id_rt_i] != 0)).
- stall_front_o = stall | freeze. bubble_ex_o = stall & ~freeze.
- With LOAD_LAT=2 this gives the classic single bubble on load-use.
- freeze_o = mem_busy_i. While frozen:
  - no issue, no decrement, no flush output;
  - branch_taken_i is ignored; it stays asserted because the resolve stage holds.
- Flush: on branch_taken_i & ~freeze:
  - flush_if_id_o = flush_id_ex_o = 1;
  - flush_ex_mem_o = (BR_STAGE == 3);
  - scoreboard cleared entirely. This is safe because every older instruction has cnt = 0 by resolve time.
  - flush overrides stall: bubble_ex_o = 0, stall_front_o = 0 so the PC loads the target.
- Forwarding (combinational), per operand src:
  - FWD_MEM if mem_regwrite_i & ~mem_memread_i & mem_dst_i == src & src != 0;
  - else FWD_WB if wb_regwrite_i & wb_dst_i == src & src != 0;
  - else FWD_REG. MEM has priority over WB.
- Outputs are combinational from state and inputs. Zero added latency.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - perf_stall_cnt_o increments each cycle stall_front_o = 1;
  - perf_flush_cnt_o increments per accepted branch flush;
  - both counters wrap at 2**32 and reset to 0.
- Undefined: both outputs tied to 0; no counter flops.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - forward select encoding: FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10;
  - BR_STAGE_EX = 2, BR_STAGE_MEM = 3.
- Sub-module hazard_scoreboard holds the cnt array, set/decrement/clear logic and the two read ports. The top keeps stall, flush, forwarding and perf logic.

Test Plan:
- Load-use: lw r5 issued, next ID uses rs=5, LOAD_LAT=2 -> bubble_ex_o=1 for exactly 1 cycle, then fwd_a_o=FWD_WB in EX.
- Back-to-back ALU: add r3, then sub using r3 -> no stall, fwd_a_o=FWD_MEM. Same with r0 as source -> fwd=FWD_REG.
- Branch at BR_STAGE=3 with a pending load-use stall -> flush_if_id/id_ex/ex_mem all 1 for 1 cycle, bubble 0, scoreboard all zero next cycle. Repeat with BR_STAGE=2 -> flush_ex_mem_o=0.
- mem_busy_i high 3 cycles during a load-use stall -> freeze_o=1 for 3 cycles, cnt unchanged, then 1 bubble after release. A concurrent branch_taken_i flushes only on the first unfrozen cycle.
- Async reset asserted mid-stall -> all outputs 0 immediately; after release, an ID use of the previously pending register does not stall.
- HAZARD_PERF_EN: 2 stall cycles + 1 flush -> perf_stall_cnt_o=2, perf_flush_cnt_o=1. Without the macro -> both 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: EX operand forward
// select and branch resolve stage identifiers.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    localparam int BR_STAGE_EX  = 2;
    localparam int BR_STAGE_MEM = 3;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register result-ready countdowns: set on issue, decrement each unfrozen
// cycle, bulk clear on flush; two combinational "still pending" read ports.
module hazard_scoreboard
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 32,
    parameter int CNT_W      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  hold_i,
    input  logic                  set_en_i,
    input  logic [REG_ADDR_W-1:0] set_idx_i,
    input  logic [CNT_W-1:0]      set_val_i,
    input  logic [REG_ADDR_W-1:0] rd_a_idx_i,
    input  logic [REG_ADDR_W-1:0] rd_b_idx_i,
    output logic                  rd_a_busy_o,
    output logic                  rd_b_busy_o
);

    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];

    // Entry 0 stays at zero: r0 is hardwired and never produces a hazard.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (r == 0 || clear_i) begin
                cnt_d[r] = '0;
            end else if (!hold_i) begin
                if (set_en_i && set_idx_i == REG_ADDR_W'(r)) begin
                    cnt_d[r] = set_val_i;
                end else if (cnt_q[r] != '0) begin
                    cnt_d[r] = cnt_q[r] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    always_comb begin
        rd_a_busy_o = 1'b0;
        rd_b_busy_o = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (rd_a_idx_i == REG_ADDR_W'(r) && cnt_q[r] != '0) rd_a_busy_o = 1'b1;
            if (rd_b_idx_i == REG_ADDR_W'(r) && cnt_q[r] != '0) rd_b_busy_o = 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline control: scoreboard stall, branch flush, EX forwarding, memory freeze.
// Zero added latency (outputs combinational); HAZARD_PERF_EN adds stall/flush perf counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 32,
    parameter int LOAD_LAT   = 2,
    parameter int CNT_W      = 2,
    parameter int BR_STAGE   = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_use_rs_i,
    input  logic                  id_use_rt_i,
    input  logic                  id_regwrite_i,
    input  logic                  id_memread_i,
    input  logic [REG_ADDR_W-1:0] id_dst_i,
    input  logic [REG_ADDR_W-1:0] ex_rs_i,
    input  logic [REG_ADDR_W-1:0] ex_rt_i,
    input  logic                  mem_regwrite_i,
    input  logic                  mem_memread_i,
    input  logic [REG_ADDR_W-1:0] mem_dst_i,
    input  logic                  wb_regwrite_i,
    input  logic [REG_ADDR_W-1:0] wb_dst_i,
    input  logic                  branch_taken_i,
    input  logic                  mem_busy_i,
    output logic                  stall_front_o,
    output logic                  bubble_ex_o,
    output logic                  freeze_o,
    output logic                  flush_if_id_o,
    output logic                  flush_id_ex_o,
    output logic                  flush_ex_mem_o,
    output logic [1:0]            fwd_a_o,
    output logic [1:0]            fwd_b_o,
    output logic [31:0]           perf_stall_cnt_o,
    output logic [31:0]           perf_flush_cnt_o
);

    localparam bit FLUSH_EX_MEM = (BR_STAGE == BR_STAGE_MEM);

    logic             freeze, flush, stall, issue;
    logic             rs_busy, rt_busy;
    logic             set_en;
    logic [CNT_W-1:0] set_val;

    assign freeze  = mem_busy_i;
    // The resolve stage holds its branch while frozen, so it is taken on release.
    assign flush   = branch_taken_i & ~freeze;
    assign stall   = id_valid_i & ((id_use_rs_i & rs_busy) | (id_use_rt_i & rt_busy));
    assign issue   = id_valid_i & ~stall & ~freeze & ~flush;
    assign set_en  = issue & id_regwrite_i & (id_dst_i != '0);
    assign set_val = id_memread_i ? CNT_W'(LOAD_LAT - 1) : '0;

    hazard_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_REGS   (NUM_REGS),
        .CNT_W      (CNT_W)
    ) u_sb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (flush),
        .hold_i      (freeze),
        .set_en_i    (set_en),
        .set_idx_i   (id_dst_i),
        .set_val_i   (set_val),
        .rd_a_idx_i  (id_rs_i),
        .rd_b_idx_i  (id_rt_i),
        .rd_a_busy_o (rs_busy),
        .rd_b_busy_o (rt_busy)
    );

    function automatic fwd_sel_e fwd_pick(input logic [REG_ADDR_W-1:0] src);
        if (src == '0)                                              return FWD_REG;
        if (mem_regwrite_i && !mem_memread_i && mem_dst_i == src)   return FWD_MEM;
        if (wb_regwrite_i && wb_dst_i == src)                       return FWD_WB;
        return FWD_REG;
    endfunction

    assign freeze_o       = ~rst_i & freeze;
    assign stall_front_o  = ~rst_i & (stall | freeze) & ~flush;
    assign bubble_ex_o    = ~rst_i & stall & ~freeze & ~flush;
    assign flush_if_id_o  = ~rst_i & flush;
    assign flush_id_ex_o  = ~rst_i & flush;
    assign flush_ex_mem_o = ~rst_i & flush & FLUSH_EX_MEM;
    assign fwd_a_o        = rst_i ? 2'b00 : fwd_pick(ex_rs_i);
    assign fwd_b_o        = rst_i ? 2'b00 : fwd_pick(ex_rt_i);

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall_front_o) perf_stall_q <= perf_stall_q + 32'd1;
            if (flush_if_id_o) perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign perf_stall_cnt_o = perf_stall_q;
    assign perf_flush_cnt_o = perf_flush_q;
`else
    assign perf_stall_cnt_o = '0;
    assign perf_flush_cnt_o = '0;
`endif

endmodule
